// File: rtl/clk_1mhz_spi_controller_if.sv
// clk_1mhz_spi_controller_if: frame word and SX1278 SPI pins of the 1 MHz controller.
// master = controller side, slave = the environment that supplies i_data and MISO.
interface clk_1mhz_spi_controller_if;
   logic [15:0] i_data;
   logic        i_spi_miso;
   logic        o_spi_cs_l;
   logic        o_spi_clk;
   logic        o_spi_mosi;
   logic [7:0]  o_spi_miso_data;
   logic        o_tick;
   modport master (input i_data, i_spi_miso,
                   output o_spi_cs_l, o_spi_clk, o_spi_mosi, o_spi_miso_data, o_tick);
   modport slave  (output i_data, i_spi_miso,
                   input o_spi_cs_l, o_spi_clk, o_spi_mosi, o_spi_miso_data, o_tick);
endinterface

// File: rtl/clk_1mhz_spi_controller.sv
// clk_1mhz_spi_controller: free-running 16-bit mode-0 SPI master for the SX1278, stepped by a
// 1 MHz tick derived from i_clk; keeps the last 8 MISO bits of each frame.
module clk_1mhz_spi_controller #(
   parameter int CLK_DIV    = 50,
   parameter int IDLE_TICKS = 4
) (
   input logic i_clk,
   input logic i_rst,
   clk_1mhz_spi_controller_if.master bus
);
   localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int IW = IDLE_TICKS > 1 ? $clog2(IDLE_TICKS) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);
   localparam logic [1:0] IDLE = 2'd0, TRANSFER = 2'd1, DONE = 2'd2;
   logic [CW-1:0] div_q, div_d;
   logic [1:0]    st_q, st_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [3:0]    bit_q, bit_d;
   logic [15:0]   sh_q, sh_d;
   logic [7:0]    rx_q, rx_d, rd_q, rd_d;
   logic          cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, tick;
   assign tick  = div_q == DIV_LAST;
   assign div_d = tick ? '0 : div_q + 1'b1;
   // Only the final 8 samples ever reach o_spi_miso_data, so the receive window is 8 bits deep.
   always_comb begin
      st_d   = st_q;
      idle_d = idle_q;
      bit_d  = bit_q;
      sh_d   = sh_q;
      rx_d   = rx_q;
      rd_d   = rd_q;
      cs_d   = cs_q;
      sclk_d = sclk_q;
      mosi_d = mosi_q;
      if (tick) begin
         case (st_q)
            IDLE:
               if (idle_q == IDLE_LAST) begin
                  idle_d = '0;
                  sh_d   = {bus.i_data[14:0], 1'b0};
                  mosi_d = bus.i_data[15];
                  cs_d   = 1'b0;
                  bit_d  = '0;
                  st_d   = TRANSFER;
               end else idle_d = idle_q + 1'b1;
            TRANSFER:
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[6:0], bus.i_spi_miso};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == 4'd15) st_d = DONE;
                  else begin
                     mosi_d = sh_q[15];
                     sh_d   = {sh_q[14:0], 1'b0};
                     bit_d  = bit_q + 4'd1;
                  end
               end
            DONE: begin
               cs_d = 1'b1;
               rd_d = rx_q;
               st_d = IDLE;
            end
            default: st_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         div_q  <= '0;
         st_q   <= IDLE;
         idle_q <= '0;
         bit_q  <= '0;
         sh_q   <= '0;
         rx_q   <= '0;
         rd_q   <= '0;
         cs_q   <= 1'b1;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         st_q   <= st_d;
         idle_q <= idle_d;
         bit_q  <= bit_d;
         sh_q   <= sh_d;
         rx_q   <= rx_d;
         rd_q   <= rd_d;
         cs_q   <= cs_d;
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
      end
   assign bus.o_tick          = tick;
   assign bus.o_spi_cs_l      = cs_q;
   assign bus.o_spi_clk       = sclk_q;
   assign bus.o_spi_mosi      = mosi_q;
   assign bus.o_spi_miso_data = rd_q;
endmodule

// File: tb/tb_clk_1mhz_spi_controller.sv
// tb_clk_1mhz_spi_controller: directed and random frames checked against a frame-level model
// (words latched at CS fall, bits collected on SCLK rises, timing measured in i_clk cycles).
module tb_clk_1mhz_spi_controller;
   localparam int CLK_DIV    = 50;
   localparam int IDLE_TICKS = 4;
   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   int tests = 0, fails = 0;
   int cyc, last_tick, first_tick, last_fall, last_rise, first_fall, nrise;
   bit in_frame, ev_fall, ev_rise, pcs, pclk, pmosi;
   logic [7:0]  pmd;
   logic [15:0] mp, cur_mp, exp_word, got, last_word, w0;
   clk_1mhz_spi_controller_if bus();
   clk_1mhz_spi_controller #(.CLK_DIV(CLK_DIV), .IDLE_TICKS(IDLE_TICKS)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );
   always #10 i_clk = ~i_clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic check_reset(input string tag);
      check({tag, "_cs"},   32'(bus.o_spi_cs_l), 32'd1);
      check({tag, "_sclk"}, 32'(bus.o_spi_clk), 32'd0);
      check({tag, "_mosi"}, 32'(bus.o_spi_mosi), 32'd0);
      check({tag, "_md"},   32'(bus.o_spi_miso_data), 32'd0);
      check({tag, "_tick"}, 32'(bus.o_tick), 32'd0);
   endtask
   task automatic mon_reset();
      cyc = 0; last_tick = -1; first_tick = -1; last_fall = -1; last_rise = -1; first_fall = -1;
      nrise = 0; in_frame = 0;
      pcs = bus.o_spi_cs_l; pclk = bus.o_spi_clk; pmosi = bus.o_spi_mosi; pmd = bus.o_spi_miso_data;
   endtask
   // One cycle of the frame model; i_data is captured before the edge it is sampled on.
   task automatic step();
      logic [15:0] dseen;
      dseen = bus.i_data;
      @(negedge i_clk);
      cyc++;
      ev_fall = pcs && !bus.o_spi_cs_l;
      ev_rise = !pcs && bus.o_spi_cs_l;
      if (bus.o_tick) begin
         if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'(CLK_DIV));
         else first_tick = cyc;
         last_tick = cyc;
      end
      if (bus.o_spi_cs_l) check("sclk_idle", 32'(bus.o_spi_clk), 32'd0);
      if (bus.o_spi_mosi !== pmosi) check("mosi_edge", 32'(ev_fall || (pclk && !bus.o_spi_clk)), 32'd1);
      if (bus.o_spi_miso_data !== pmd) check("md_change", 32'(ev_rise), 32'd1);
      if (ev_fall) begin
         if (first_fall < 0) first_fall = cyc;
         if (last_rise >= 0) check("cs_high", 32'(cyc - last_rise), 32'(IDLE_TICKS * CLK_DIV));
         if (last_fall >= 0) check("period", 32'(cyc - last_fall), 32'((33 + IDLE_TICKS) * CLK_DIV));
         last_fall = cyc; exp_word = dseen; cur_mp = mp; got = '0; nrise = 0; in_frame = 1;
         bus.i_spi_miso = mp[15];
      end
      if (in_frame && !pclk && bus.o_spi_clk) begin
         got = {got[14:0], bus.o_spi_mosi};
         nrise++;
         if (nrise < 16) bus.i_spi_miso = cur_mp[15 - nrise];
      end
      if (ev_rise && in_frame) begin
         check("cs_low", 32'(cyc - last_fall), 32'(33 * CLK_DIV));
         check("rises", 32'(nrise), 32'd16);
         check("mosi_word", 32'(got), 32'(exp_word));
         check("miso_byte", 32'(bus.o_spi_miso_data), 32'(cur_mp[7:0]));
         last_word = got; last_rise = cyc; in_frame = 0;
      end
      pcs = bus.o_spi_cs_l; pclk = bus.o_spi_clk; pmosi = bus.o_spi_mosi; pmd = bus.o_spi_miso_data;
   endtask
   task automatic mon(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic mon_until(input bit want_rise, input string tag);
      bit found;
      found = 0;
      for (int i = 0; i < 4000 && !found; i++) begin
         step();
         found = want_rise ? ev_rise : ev_fall;
      end
      check(tag, 32'(found), 32'd1);
   endtask
   initial begin
      bus.i_data = 16'h8181; bus.i_spi_miso = 1'b0; mp = 16'h3C5A;
      repeat (5) @(negedge i_clk);
      check_reset("por");
      i_rst = 1'b1; mon_reset();
      mon_until(0, "fall_8181");
      check("first_tick", 32'(first_tick), 32'(CLK_DIV - 1));
      check("first_fall", 32'(first_fall), 32'(IDLE_TICKS * CLK_DIV));
      mon_until(1, "frame_8181");
      check("word_8181", 32'(last_word), 32'h8181);
      bus.i_data = 16'h1200; mp = 16'hFF08;
      mon_until(1, "frame_1200");
      check("word_1200", 32'(last_word), 32'h1200);
      check("readback", 32'(bus.o_spi_miso_data), 32'h08);
      bus.i_data = 16'h8D00;
      mon_until(0, "fall_8d00");
      mon(10 * CLK_DIV);
      bus.i_data = 16'h8980;
      mon_until(1, "frame_8d00");
      check("word_8d00", 32'(last_word), 32'h8D00);
      mon_until(1, "frame_8980");
      check("word_8980", 32'(last_word), 32'h8980);
      w0 = 16'($urandom); bus.i_data = w0;
      for (int i = 0; i < 3; i++) begin
         mon_until(1, "frame_b2b");
         check("word_b2b", 32'(last_word), 32'(w0));
      end
      for (int i = 0; i < 6; i++) begin
         bus.i_data = 16'($urandom); mp = 16'($urandom);
         mon_until(0, "fall_rnd");
         mon(int'($urandom_range(1, 30 * CLK_DIV)));
         bus.i_data = 16'($urandom);
         mon_until(1, "frame_rnd");
      end
      mp = 16'h00A5;
      mon_until(1, "frame_a5");
      check("pre_rst_md", 32'(bus.o_spi_miso_data), 32'hA5);
      mon_until(0, "fall_pre_rst");
      mon(700);
      i_rst = 1'b0;
      #1;
      check_reset("async");
      repeat (10) @(negedge i_clk);
      check_reset("held");
      i_rst = 1'b1; mon_reset();
      mon_until(0, "fall_post_rst");
      check("rst_first_tick", 32'(first_tick), 32'(CLK_DIV - 1));
      check("rst_first_fall", 32'(first_fall), 32'(IDLE_TICKS * CLK_DIV));
      mon_until(1, "frame_post_rst");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
